// File: rtl/dt_est_pkg.sv
// Shared types and helpers for the temperature-difference estimators.
// Holds the FSM state type, the unity alpha constant and the clamp function.
package dt_est_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      OUT
   } dt_state_e;

   localparam logic [8:0] ALPHA_ONE = 9'd256;

   // Symmetric clamp of v into [-lim, +lim]; lim is assumed >= 0.
   function automatic logic signed [31:0] sat_clamp(
      input logic signed [31:0] v,
      input logic signed [31:0] lim
   );
      if (v > lim)
         return lim;
      else if (v < -lim)
         return -lim;
      else
         return v;
   endfunction

endpackage

// File: rtl/dt_ema_mac.sv
// Combinational delta / pre-shift / EMA update / clamp for one sample.
// Ports: primed, t_in, t_prev, acc, alpha, k_dt, d_max in;
//        acc_nxt, dt out (+ sat when DT_EST_SAT_FLAG_EN is defined).
module dt_ema_mac
   import dt_est_pkg::*;
#(
   parameter int W    = 8,
   parameter int FRAC = 8,
   localparam int AW  = W + 1 + FRAC
) (
   input  logic          primed,
   input  logic [W-1:0]  t_in,
   input  logic [W-1:0]  t_prev,
   input  logic [AW-1:0] acc,
   input  logic [8:0]    alpha,
   input  logic [3:0]    k_dt,
   input  logic [W-1:0]  d_max,
   output logic [AW-1:0] acc_nxt,
   output logic [W-1:0]  dt
`ifdef DT_EST_SAT_FLAG_EN
   ,
   output logic          sat
`endif
);

   // Headroom for a 9-bit weight times an AW-bit operand plus the sum carry.
   localparam int PW = AW + 11;

   logic        [3:0]    k;
   logic        [8:0]    a;
   logic signed [W:0]    delta;
   logic signed [W:0]    dsh;
   logic signed [PW-1:0] acc_x;
   logic signed [PW-1:0] dlt_x;
   logic signed [PW-1:0] wa;
   logic signed [PW-1:0] wb;
   logic signed [PW-1:0] sum;
   logic signed [AW-1:0] acc_new;
   logic signed [W:0]    est;
   logic signed [31:0]   est32;
   logic signed [31:0]   lim32;

   always_comb begin
      k = (int'(k_dt) > W) ? 4'(W) : k_dt;
      a = (alpha > ALPHA_ONE) ? ALPHA_ONE : alpha;
      // One extra bit so a full-scale jump cannot wrap.
      delta = $signed({t_in[W-1], t_in})
            - $signed({t_prev[W-1], t_prev});
      dsh   = delta >>> k;
      acc_x = {{(PW-AW){acc[AW-1]}}, acc};
      dlt_x = {{(PW-AW){dsh[W]}}, dsh, {FRAC{1'b0}}};
      wa    = {{(PW-9){1'b0}}, a};
      wb    = {{(PW-9){1'b0}}, 9'(ALPHA_ONE - a)};
      sum   = wb * acc_x + wa * dlt_x;
      // Convex blend, so the floored result always fits back into AW bits.
      acc_new = AW'(sum >>> 8);
      est     = acc_new[AW-1:FRAC];
      est32   = {{(32-W-1){est[W]}}, est};
      lim32   = d_max[W-1] ? '0 : {{(32-W){1'b0}}, d_max};
      acc_nxt = '0;
      dt      = '0;
`ifdef DT_EST_SAT_FLAG_EN
      sat     = 1'b0;
`endif
      if (primed) begin
         acc_nxt = acc_new;
         dt      = W'(sat_clamp(est32, lim32));
`ifdef DT_EST_SAT_FLAG_EN
         sat     = sat_clamp(est32, lim32) != est32;
`endif
      end
   end

endmodule

// File: rtl/dt_estimator_mc.sv
// Multi-channel EMA estimator of sample-to-sample temperature difference.
// Ports: clk, rst (async, active-high), init, in_valid/in_ready/in_ch/T_in,
//        ALPHA, K_DT, D_MAX, out_valid/out_ready/out_ch/dT_out.
// Optional: DT_EST_SAT_FLAG_EN adds sat_flag and sat_sticky[N_CH].
module dt_estimator_mc
   import dt_est_pkg::*;
#(
   parameter int W    = 8,
   parameter int FRAC = 8,
   parameter int N_CH = 4,
   localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_ch,
   input  logic [W-1:0]  T_in,
   input  logic [8:0]    ALPHA,
   input  logic [3:0]    K_DT,
   input  logic [W-1:0]  D_MAX,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_ch,
   output logic [W-1:0]  dT_out
`ifdef DT_EST_SAT_FLAG_EN
   ,
   output logic            sat_flag,
   output logic [N_CH-1:0] sat_sticky
`endif
);

   localparam int AW = W + 1 + FRAC;

   dt_state_e state;
   dt_state_e state_nxt;

   logic [CW-1:0]   l_ch;
   logic [W-1:0]    l_t;
   logic [8:0]      l_alpha;
   logic [3:0]      l_k;
   logic [W-1:0]    l_dmax;

   logic [W-1:0]    t_prev [N_CH];
   logic [AW-1:0]   acc    [N_CH];
   logic [N_CH-1:0] primed;

   logic            ch_ok;
   logic [CW-1:0]   idx;
   logic [AW-1:0]   acc_nxt;
   logic [W-1:0]    dt_nxt;
`ifdef DT_EST_SAT_FLAG_EN
   logic            sat_nxt;
`endif

   // Out-of-range channels are swallowed in CALC; idx keeps reads in range.
   assign ch_ok = int'(l_ch) < N_CH;
   assign idx   = ch_ok ? l_ch : '0;

   dt_ema_mac #(
      .W    (W),
      .FRAC (FRAC)
   ) u_mac (
      .primed  (primed[idx]),
      .t_in    (l_t),
      .t_prev  (t_prev[idx]),
      .acc     (acc[idx]),
      .alpha   (l_alpha),
      .k_dt    (l_k),
      .d_max   (l_dmax),
      .acc_nxt (acc_nxt),
      .dt      (dt_nxt)
`ifdef DT_EST_SAT_FLAG_EN
      ,
      .sat     (sat_nxt)
`endif
   );

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      if (init) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               in_ready = 1'b1;
               if (in_valid)
                  state_nxt = CALC;
            end
            CALC: state_nxt = ch_ok ? OUT : IDLE;
            OUT: begin
               out_valid = 1'b1;
               if (out_ready)
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_ch    <= '0;
         l_t     <= '0;
         l_alpha <= '0;
         l_k     <= '0;
         l_dmax  <= '0;
         primed  <= '0;
         out_ch  <= '0;
         dT_out  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            t_prev[i] <= '0;
            acc[i]    <= '0;
         end
`ifdef DT_EST_SAT_FLAG_EN
         sat_flag   <= 1'b0;
         sat_sticky <= '0;
`endif
      end else if (init) begin
         primed <= '0;
`ifdef DT_EST_SAT_FLAG_EN
         sat_sticky <= '0;
`endif
      end else begin
         if (state == IDLE && in_valid) begin
            l_ch    <= in_ch;
            l_t     <= T_in;
            l_alpha <= ALPHA;
            l_k     <= K_DT;
            l_dmax  <= D_MAX;
         end
         if (state == CALC && ch_ok) begin
            t_prev[idx] <= l_t;
            acc[idx]    <= acc_nxt;
            primed[idx] <= 1'b1;
            out_ch      <= l_ch;
            dT_out      <= dt_nxt;
`ifdef DT_EST_SAT_FLAG_EN
            sat_flag    <= sat_nxt;
            if (sat_nxt)
               sat_sticky[idx] <= 1'b1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_dt_estimator_mc.sv
// Self-checking bench for dt_estimator_mc (5 channels, W=8, FRAC=8).
// Directed scenarios plus randomized samples against a behavioural model.
module tb_dt_estimator_mc;

   localparam int NC = 5;

   logic          clk;
   logic          rst;
   logic          init;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_ch;
   logic [7:0]    T_in;
   logic [8:0]    ALPHA;
   logic [3:0]    K_DT;
   logic [7:0]    D_MAX;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    out_ch;
   logic [7:0]    dT_out;
`ifdef DT_EST_SAT_FLAG_EN
   logic          sat_flag;
   logic [NC-1:0] sat_sticky;
`endif

   int n_chk;
   int n_fail;

   bit m_pr   [NC];
   int m_prev [NC];
   int m_acc  [NC];

   dt_estimator_mc #(
      .W    (8),
      .FRAC (8),
      .N_CH (NC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .init      (init),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ch     (in_ch),
      .T_in      (T_in),
      .ALPHA     (ALPHA),
      .K_DT      (K_DT),
      .D_MAX     (D_MAX),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .dT_out    (dT_out)
`ifdef DT_EST_SAT_FLAG_EN
      ,
      .sat_flag   (sat_flag),
      .sat_sticky (sat_sticky)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_clear();
      for (int i = 0; i < NC; i++) begin
         m_pr[i]   = 1'b0;
         m_prev[i] = 0;
         m_acc[i]  = 0;
      end
   endfunction

   // EMA in plain integer arithmetic; >>> on int floors toward -inf.
   function automatic void model(
      input int ch, input int t, input int alpha,
      input int k, input int dmax,
      output int e_dt, output bit e_sat
   );
      int a, kk, lim, d, est;
      a   = (alpha > 256) ? 256 : alpha;
      kk  = (k > 8) ? 8 : k;
      lim = (dmax < 0) ? 0 : dmax;
      e_dt  = 0;
      e_sat = 1'b0;
      if (!m_pr[ch]) begin
         m_pr[ch]   = 1'b1;
         m_prev[ch] = t;
         m_acc[ch]  = 0;
      end else begin
         d = (t - m_prev[ch]) >>> kk;
         m_acc[ch]  = ((256 - a) * m_acc[ch] + a * d * 256) >>> 8;
         m_prev[ch] = t;
         est  = m_acc[ch] >>> 8;
         e_dt = (est > lim) ? lim : (est < -lim) ? -lim : est;
         e_sat = e_dt != est;
      end
   endfunction

   task automatic offer(
      input int ch, input int t, input int alpha,
      input int k, input int dmax,
      output bit acc, output bit got
   );
      @(negedge clk);
      in_ch    = 3'(ch);
      T_in     = 8'(t);
      ALPHA    = 9'(alpha);
      K_DT     = 4'(k);
      D_MAX    = 8'(dmax);
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         if (in_ready) begin
            acc = 1'b1;
            @(posedge clk);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         if (out_valid)
            got = 1'b1;
         else
            @(negedge clk);
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_hs: rdy/vld=%b want 10",
                  {in_ready, out_valid});
      end
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({out_ch, dT_out} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_out: ch=%0d dt=%0d want 0 0",
                  out_ch, dT_out);
      end
      model_clear();
   endtask

   task automatic test_prime();
      int tbl [2][6] = '{'{0, 20, 256, 0, 127, 0},
                         '{0, 20, 256, 0, 127, 0}};
      int md;
      bit ms, a, g;
      foreach (tbl[i]) begin
         offer(tbl[i][0], tbl[i][1], tbl[i][2],
               tbl[i][3], tbl[i][4], a, g);
         model(tbl[i][0], tbl[i][1], tbl[i][2],
               tbl[i][3], tbl[i][4], md, ms);
         n_chk++;
         if ({a, g} !== 2'b11 || int'(out_ch) !== tbl[i][0]
             || int'($signed(dT_out)) !== tbl[i][5]) begin
            n_fail++;
            $display("FAIL prime[%0d]: hs=%b ch=%0d dt=%0d want 11 %0d %0d",
                     i, {a, g}, out_ch, $signed(dT_out),
                     tbl[i][0], tbl[i][5]);
         end
         if (g) consume();
      end
   endtask

   task automatic test_step();
      int tbl [4][6] = '{'{1, 0, 256, 0, 127, 0},
                         '{1, 10, 256, 0, 127, 10},
                         '{1, 10, 128, 0, 127, 5},
                         '{1, 50, 0, 0, 127, 5}};
      int md;
      bit ms, a, g;
      foreach (tbl[i]) begin
         offer(tbl[i][0], tbl[i][1], tbl[i][2],
               tbl[i][3], tbl[i][4], a, g);
         model(tbl[i][0], tbl[i][1], tbl[i][2],
               tbl[i][3], tbl[i][4], md, ms);
         n_chk++;
         if ({a, g} !== 2'b11 || int'(out_ch) !== tbl[i][0]
             || int'($signed(dT_out)) !== tbl[i][5]) begin
            n_fail++;
            $display("FAIL step[%0d]: hs=%b ch=%0d dt=%0d want 11 %0d %0d",
                     i, {a, g}, out_ch, $signed(dT_out),
                     tbl[i][0], tbl[i][5]);
         end
         if (g) consume();
      end
   endtask

   task automatic test_clamp();
      int tbl [3][6] = '{'{2, -128, 256, 0, 50, 0},
                         '{2, 127, 256, 0, 50, 50},
                         '{2, -128, 256, 0, 50, -50}};
      int md;
      bit ms, a, g;
      foreach (tbl[i]) begin
         offer(tbl[i][0], tbl[i][1], tbl[i][2],
               tbl[i][3], tbl[i][4], a, g);
         model(tbl[i][0], tbl[i][1], tbl[i][2],
               tbl[i][3], tbl[i][4], md, ms);
         n_chk++;
         if ({a, g} !== 2'b11 || int'(out_ch) !== tbl[i][0]
             || int'($signed(dT_out)) !== tbl[i][5]) begin
            n_fail++;
            $display("FAIL clamp[%0d]: hs=%b ch=%0d dt=%0d want 11 %0d %0d",
                     i, {a, g}, out_ch, $signed(dT_out),
                     tbl[i][0], tbl[i][5]);
         end
`ifdef DT_EST_SAT_FLAG_EN
         n_chk++;
         if (sat_flag !== (i != 0) || sat_sticky[2] !== (i != 0)) begin
            n_fail++;
            $display("FAIL clamp_sat[%0d]: flag=%b sticky=%b want %b",
                     i, sat_flag, sat_sticky[2], i != 0);
         end
`endif
         if (g) consume();
      end
   endtask

   task automatic test_backpressure();
      int md, ch, t, al;
      bit ms, a, g, ok;
      logic [7:0] dt0;
      logic [2:0] ch0;
      for (int i = 0; i < 6; i++) begin
         ch = (i % 2 == 0) ? 0 : 3;
         t  = int'($urandom_range(0, 255)) - 128;
         al = int'($urandom_range(0, 256));
         offer(ch, t, al, 1, 100, a, g);
         model(ch, t, al, 1, 100, md, ms);
         n_chk++;
         if ({a, g} !== 2'b11 || int'(out_ch) !== ch
             || int'($signed(dT_out)) !== md) begin
            n_fail++;
            $display("FAIL bp[%0d]: hs=%b ch=%0d dt=%0d want 11 %0d %0d",
                     i, {a, g}, out_ch, $signed(dT_out), ch, md);
         end
         dt0 = dT_out;
         ch0 = out_ch;
         ok  = 1'b1;
         in_valid = 1'b1;
         repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0
                || dT_out !== dt0 || out_ch !== ch0)
               ok = 1'b0;
         end
         in_valid = 1'b0;
         n_chk++;
         if (!ok) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: vld=%b rdy=%b dt=%0d want 1 0 %0d",
                     i, out_valid, in_ready, dT_out, dt0);
         end
         if (g) consume();
      end
   endtask

   task automatic test_random();
      int md, ch, t, al, k, dm;
      bit ms, a, g;
      for (int i = 0; i < 60; i++) begin
         ch = int'($urandom_range(0, NC - 1));
         t  = int'($urandom_range(0, 255)) - 128;
         al = int'($urandom_range(0, 300));
         k  = int'($urandom_range(0, 10));
         dm = int'($urandom_range(0, 255)) - 128;
         offer(ch, t, al, k, dm, a, g);
         model(ch, t, al, k, dm, md, ms);
         n_chk++;
         if ({a, g} !== 2'b11 || int'(out_ch) !== ch
             || int'($signed(dT_out)) !== md) begin
            n_fail++;
            $display("FAIL rand[%0d]: hs=%b ch=%0d dt=%0d want 11 %0d %0d",
                     i, {a, g}, out_ch, $signed(dT_out), ch, md);
         end
`ifdef DT_EST_SAT_FLAG_EN
         n_chk++;
         if (sat_flag !== ms) begin
            n_fail++;
            $display("FAIL rand_sat[%0d]: flag=%b want %b",
                     i, sat_flag, ms);
         end
`endif
         if (g) consume();
      end
   endtask

   task automatic test_init();
      int md, t;
      bit ms, a, g, ok;
      @(negedge clk);
      in_ch    = 3'd0;
      T_in     = 8'd77;
      ALPHA    = 9'd256;
      K_DT     = 4'd0;
      D_MAX    = 8'd127;
      in_valid = 1'b1;
      @(negedge clk);
      init = 1'b1;
      n_chk++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL init_rdy: in_ready=%b want 0", in_ready);
      end
      @(negedge clk);
      init     = 1'b0;
      in_valid = 1'b0;
      model_clear();
      ok = 1'b1;
      repeat (5) begin
         if (out_valid !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL init_abort: out_valid=%b want 0", out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         t = int'($urandom_range(0, 255)) - 128;
         offer(i, t, 256, 0, 127, a, g);
         model(i, t, 256, 0, 127, md, ms);
         n_chk++;
         if ({a, g} !== 2'b11 || int'($signed(dT_out)) !== 0) begin
            n_fail++;
            $display("FAIL init_reprime[%0d]: hs=%b dt=%0d want 11 0",
                     i, {a, g}, $signed(dT_out));
         end
         if (g) consume();
      end
   endtask

   task automatic test_async_rst();
      int md;
      bit ms, a, g;
      offer(1, 100, 256, 0, 127, a, g);
      model(1, 100, 256, 0, 127, md, ms);
      n_chk++;
      if ({a, g} !== 2'b11 || int'($signed(dT_out)) !== md) begin
         n_fail++;
         $display("FAIL arst_pre: hs=%b dt=%0d want 11 %0d",
                  {a, g}, $signed(dT_out), md);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({out_valid, in_ready, out_ch, dT_out} !== 13'b01_000_00000000)
      begin
         n_fail++;
         $display("FAIL arst_out: vld=%b rdy=%b ch=%0d dt=%0d want 0 1 0 0",
                  out_valid, in_ready, out_ch, dT_out);
      end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      offer(0, 10, 256, 0, 127, a, g);
      model(0, 10, 256, 0, 127, md, ms);
      if (g) consume();
      offer(NC, 99, 256, 0, 127, a, g);
      n_chk++;
      if ({a, g} !== 2'b10) begin
         n_fail++;
         $display("FAIL bad_ch: acc/got=%b want 10", {a, g});
      end
      if (g) consume();
      offer(0, 30, 256, 0, 127, a, g);
      model(0, 30, 256, 0, 127, md, ms);
      n_chk++;
      if ({a, g} !== 2'b11 || int'($signed(dT_out)) !== 20
          || md !== 20) begin
         n_fail++;
         $display("FAIL bad_ch_state: hs=%b dt=%0d want 11 20",
                  {a, g}, $signed(dT_out));
      end
      if (g) consume();
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      init      = 1'b0;
      in_valid  = 1'b0;
      in_ch     = '0;
      T_in      = '0;
      ALPHA     = '0;
      K_DT      = '0;
      D_MAX     = '0;
      out_ready = 1'b0;
      test_reset();
      test_prime();
      test_step();
      test_clamp();
      test_backpressure();
      test_random();
      test_init();
      test_async_rst();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
